picorv32_sync_ram: RTL and testbench
====================================

Name: picorv32_sync_ram

Overview:
- Single-port synchronous word RAM with a PicoRV32 native memory-interface front end (valid/ready handshake, byte write strobes).
- Serves both instruction fetches and data loads/stores for a PicoRV32 core in a standalone SoC and its test harness.
- Address decode, a 1-cycle synchronous read, and out-of-range handling are all in this block.

Parameters:
- Words, 256, number of 32-bit words stored; power of two, at least 4.
- BaseAddr, 32'h0000_0000, byte address of word 0; must be aligned to Words*4.

Ports:
- clk_i  in  1  single clock; all logic on the rising edge.
- reset_ni  in  1  asynchronous active-low reset.
- mem_valid_i  in  1  core request valid.
- mem_instr_i  in  1  request is an instruction fetch; informational only, treated as a read.
- mem_addr_i  in  32  byte address; bits [1:0] ignored.
- mem_wdata_i  in  32  write data.
- mem_wstrb_i  in  4  byte write enables; 0 means read.
- mem_ready_o  out  1  one-cycle response strobe.
- mem_rdata_o  out  32  read data, valid while mem_ready_o=1.
- err_o  out  1  pulses with mem_ready_o when the address is out of range.

Behaviour:
- Storage: array named mem, Words entries of 32 bits, indexed by word index. Hierarchical preload of mem[i] by the bench is supported. Contents are not reset.
- Decode:
  - idx = (mem_addr_i - BaseAddr) >> 2.
  - in_range when mem_addr_i >= BaseAddr and idx < Words.
  - Only bits [$clog2(Words)+1:2] of the offset index the array.
- FSM states: IDLE, RESP.
- IDLE:
  - When mem_valid_i=1, the request is accepted at the clock edge and the FSM moves to RESP.
  - In range with mem_wstrb_i≠0: byte lanes with strobe=1 are written (lane k = bits [8k+7:8k]); other lanes keep their value.
  - In range with mem_wstrb_i=0: synchronous read of mem[idx].
  - Out of range: no write, no read; err flag latched.
- RESP:
  - mem_ready_o=1 for exactly this one cycle, then unconditionally back to IDLE.
  - mem_valid_i is ignored while in RESP.
- Read data:
  - Read: mem_rdata_o = word as it was before any same-edge write (no write and read in one access anyway).
  - Write or out-of-range: mem_rdata_o = 0.
- Latency: request accepted at edge N, mem_ready_o high in cycle N..N+1, and the core samples it at edge N+1. Throughput is at most one access per 2 cycles.
- mem_ready_o=0 and mem_rdata_o=0 in IDLE.
- err_o=1 only in RESP for out-of-range accesses.
- Reset (asynchronous, any time, including mid-access):
  - FSM goes to IDLE.
  - mem_ready_o=0, mem_rdata_o=0, err_o=0.
  - Any write already committed at a prior edge stays; no write occurs while reset_ni=0.
- Request inputs are sampled only in IDLE; the core holds them stable until ready.

Test Plan:
- Preload mem[0..5] = 3fc00093, 0000a023, 0000a103, 00110113, 0020a023, ff5ff06f; read at 0x0,0x4,...,0x14 -> each mem_ready_o one cycle after acceptance with matching mem_rdata_o, err_o=0.
- Write 0x12345678 wstrb=1111 at 0x3FC, then read 0x3FC -> 0x12345678. Write 0xAABBCCDD wstrb=0101 at 0x3FC -> read returns 0x12BB56DD.
- Hold mem_valid_i high continuously for a read at 0x8 -> ready pulses 1 cycle, back to IDLE, re-accepted only on the following edge (pattern 0,1,0,1...).
- Read at 0x400 (Words=256, out of range) -> mem_ready_o=1, err_o=1, mem_rdata_o=0. Write to 0x400 -> no array word changes.
- Assert reset_ni=0 asynchronously while in RESP -> mem_ready_o drops immediately. mem contents are preserved, and a subsequent read of 0x0 returns 3fc00093.
- With a PicoRV32 core attached and the program above preloaded, run 200 cycles -> word 0x3FC increments by 1 each loop iteration; mem_instr_i=1 fetches are served identically to reads.

Source files
------------

// File: rtl/picorv32_sync_ram.sv
// Single-port synchronous word RAM behind a PicoRV32 native memory interface.
// Each accepted request gets a one-cycle ready strobe on the following cycle; out-of-range accesses raise err_o.
module picorv32_sync_ram #(
    parameter int unsigned Words    = 256,
    parameter logic [31:0] BaseAddr = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        mem_valid_i,
    input  logic        mem_instr_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_wstrb_i,
    output logic        mem_ready_o,
    output logic [31:0] mem_rdata_o,
    output logic        err_o
);

    localparam int unsigned AW = $clog2(Words);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RESP = 1'b1;

    logic [31:0]   mem [Words];

    logic [31:0]   offset_s;
    logic          in_range_s;
    logic [AW-1:0] idx_s;
    logic          accept_s;
    logic          wr_en_s;
    logic          rd_en_s;
    logic          unused_s;

    logic [0:0]    state_q, state_d;
    logic          ready_q, ready_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q,   err_d;

    // Address decode: word offset from the base, range check, and array index.
    always_comb begin
        offset_s   = mem_addr_i - BaseAddr;
        in_range_s = (mem_addr_i >= BaseAddr) && (offset_s[31:2] < 30'(Words));
        idx_s      = offset_s[AW+1:2];
        accept_s   = (state_q == IDLE) && mem_valid_i;
        wr_en_s    = accept_s && in_range_s && (mem_wstrb_i != 4'b0000);
        rd_en_s    = accept_s && in_range_s && (mem_wstrb_i == 4'b0000);
        // Fetches are plain reads; the instruction flag and byte offset carry no meaning here.
        unused_s   = mem_instr_i ^ offset_s[1] ^ offset_s[0];
    end

    // Next-state and response-register logic for the IDLE/RESP handshake.
    always_comb begin
        state_d = IDLE;
        ready_d = 1'b0;
        rdata_d = 32'h0000_0000;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = RESP;
                    ready_d = 1'b1;
                    rdata_d = rd_en_s ? mem[idx_s] : 32'h0000_0000;
                    err_d   = !in_range_s;
                end else begin
                    state_d = IDLE;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs, cleared asynchronously.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            rdata_q <= 32'h0000_0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Byte-lane writes; contents survive reset and no write lands while reset is held.
    always_ff @(posedge clk_i) begin
        if (wr_en_s && reset_ni) begin
            for (int k = 0; k < 4; k++) begin
                if (mem_wstrb_i[k]) begin
                    mem[idx_s][8*k +: 8] <= mem_wdata_i[8*k +: 8];
                end
            end
        end
    end

    assign mem_ready_o = ready_q;
    assign mem_rdata_o = rdata_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_picorv32_sync_ram.sv
// Directed testbench for picorv32_sync_ram: reads, byte writes, handshake timing,
// out-of-range handling and asynchronous reset mid-response.
module tb_picorv32_sync_ram;

    logic        clk;
    logic        reset_ni;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        err;

    int asserts_cnt;
    int fail_cnt;

    logic        r_ready, r_err, i_ready, i_err;
    logic [31:0] r_rdata, i_rdata;

    logic [31:0] prog [6];

    picorv32_sync_ram #(.Words(256), .BaseAddr(32'h0000_0000)) dut (
        .clk_i       (clk),
        .reset_ni    (reset_ni),
        .mem_valid_i (mem_valid),
        .mem_instr_i (mem_instr),
        .mem_addr_i  (mem_addr),
        .mem_wdata_i (mem_wdata),
        .mem_wstrb_i (mem_wstrb),
        .mem_ready_o (mem_ready),
        .mem_rdata_o (mem_rdata),
        .err_o       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One complete access: response sampled after the accepting edge, idle state one edge later.
    task automatic access(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic instr);
        @(negedge clk);
        mem_valid = 1'b1;
        mem_instr = instr;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        @(posedge clk);
        #1;
        r_ready = mem_ready;
        r_rdata = mem_rdata;
        r_err   = err;
        @(negedge clk);
        mem_valid = 1'b0;
        mem_instr = 1'b0;
        mem_wstrb = 4'b0000;
        @(posedge clk);
        #1;
        i_ready = mem_ready;
        i_rdata = mem_rdata;
        i_err   = err;
    endtask

    task automatic test_reset();
        reset_ni  = 1'b0;
        mem_valid = 1'b0;
        mem_instr = 1'b0;
        mem_addr  = 32'h0000_0000;
        mem_wdata = 32'h0000_0000;
        mem_wstrb = 4'b0000;
        for (int i = 0; i < 6; i++) dut.mem[i] = prog[i];
        repeat (2) @(posedge clk);
        #1;
        asserts_cnt++;
        if ({mem_ready, err, mem_rdata} !== 34'h0) begin
            fail_cnt++;
            $display("FAIL reset_outputs: got ready=%b err=%b rdata=%h, expected 0/0/0", mem_ready, err, mem_rdata);
        end
        @(negedge clk);
        reset_ni = 1'b1;
    endtask

    task automatic test_read_program();
        for (int i = 0; i < 6; i++) begin
            access(32'(i * 4), 32'h0, 4'b0000, i[0]);
            asserts_cnt++;
            if (r_ready !== 1'b1 || r_err !== 1'b0 || r_rdata !== prog[i]) begin
                fail_cnt++;
                $display("FAIL read_word%0d: got ready=%b err=%b rdata=%h, expected 1/0/%h", i, r_ready, r_err, r_rdata, prog[i]);
            end
            asserts_cnt++;
            if (i_ready !== 1'b0 || i_err !== 1'b0 || i_rdata !== 32'h0) begin
                fail_cnt++;
                $display("FAIL idle_after_read%0d: got ready=%b err=%b rdata=%h, expected 0/0/0", i, i_ready, i_err, i_rdata);
            end
        end
    endtask

    task automatic test_byte_write();
        access(32'h0000_03FC, 32'h1234_5678, 4'b1111, 1'b0);
        asserts_cnt++;
        if (r_ready !== 1'b1 || r_err !== 1'b0 || r_rdata !== 32'h0) begin
            fail_cnt++;
            $display("FAIL write_resp: got ready=%b err=%b rdata=%h, expected 1/0/0", r_ready, r_err, r_rdata);
        end
        access(32'h0000_03FC, 32'h0, 4'b0000, 1'b0);
        asserts_cnt++;
        if (r_rdata !== 32'h1234_5678) begin
            fail_cnt++;
            $display("FAIL write_full: got %h, expected 12345678", r_rdata);
        end
        access(32'h0000_03FC, 32'hAABB_CCDD, 4'b0101, 1'b0);
        access(32'h0000_03FE, 32'h0, 4'b0000, 1'b0);
        asserts_cnt++;
        if (r_rdata !== 32'h12BB_56DD) begin
            fail_cnt++;
            $display("FAIL write_lanes: got %h, expected 12bb56dd", r_rdata);
        end
        access(32'h0000_0040, 32'hCAFE_F00D, 4'b1010, 1'b0);
        access(32'h0000_0040, 32'h0, 4'b0000, 1'b0);
        asserts_cnt++;
        if (r_rdata[31:24] !== 8'hCA || r_rdata[15:8] !== 8'hF0) begin
            fail_cnt++;
            $display("FAIL write_lanes_hi: got %h, expected CA..F0..", r_rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_ready;
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = 32'h0000_0008;
        mem_wstrb = 4'b0000;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            exp_ready = (c % 2 == 0);
            asserts_cnt++;
            if (mem_ready !== exp_ready || mem_rdata !== (exp_ready ? 32'h0000_a103 : 32'h0)) begin
                fail_cnt++;
                $display("FAIL held_valid_c%0d: got ready=%b rdata=%h, expected %b/%h", c, mem_ready, mem_rdata,
                         exp_ready, exp_ready ? 32'h0000_a103 : 32'h0);
            end
        end
        @(negedge clk);
        mem_valid = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_out_of_range();
        access(32'h0000_0400, 32'h0, 4'b0000, 1'b0);
        asserts_cnt++;
        if (r_ready !== 1'b1 || r_err !== 1'b1 || r_rdata !== 32'h0) begin
            fail_cnt++;
            $display("FAIL oor_read: got ready=%b err=%b rdata=%h, expected 1/1/0", r_ready, r_err, r_rdata);
        end
        asserts_cnt++;
        if (i_err !== 1'b0 || i_ready !== 1'b0) begin
            fail_cnt++;
            $display("FAIL oor_err_clear: got ready=%b err=%b, expected 0/0", i_ready, i_err);
        end
        access(32'hFFFF_FFFC, 32'h0, 4'b0000, 1'b0);
        asserts_cnt++;
        if (r_err !== 1'b1 || r_rdata !== 32'h0) begin
            fail_cnt++;
            $display("FAIL oor_top: got err=%b rdata=%h, expected 1/0", r_err, r_rdata);
        end
        access(32'h0000_0400, 32'hDEAD_BEEF, 4'b1111, 1'b0);
        asserts_cnt++;
        if (r_err !== 1'b1) begin
            fail_cnt++;
            $display("FAIL oor_write_err: got err=%b, expected 1", r_err);
        end
        access(32'h0000_0000, 32'h0, 4'b0000, 1'b0);
        asserts_cnt++;
        if (r_rdata !== 32'h3fc0_0093 || r_err !== 1'b0) begin
            fail_cnt++;
            $display("FAIL oor_no_alias: got err=%b rdata=%h, expected 0/3fc00093", r_err, r_rdata);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = 32'h0000_0014;
        mem_wstrb = 4'b0000;
        @(posedge clk);
        #1;
        asserts_cnt++;
        if (mem_ready !== 1'b1 || mem_rdata !== 32'hff5f_f06f) begin
            fail_cnt++;
            $display("FAIL rst_pre: got ready=%b rdata=%h, expected 1/ff5ff06f", mem_ready, mem_rdata);
        end
        #1;
        reset_ni  = 1'b0;
        #1;
        asserts_cnt++;
        if (mem_ready !== 1'b0 || mem_rdata !== 32'h0 || err !== 1'b0) begin
            fail_cnt++;
            $display("FAIL rst_async: got ready=%b err=%b rdata=%h, expected 0/0/0", mem_ready, err, mem_rdata);
        end
        mem_valid = 1'b0;
        @(negedge clk);
        reset_ni = 1'b1;
        access(32'h0000_0000, 32'h0, 4'b0000, 1'b1);
        asserts_cnt++;
        if (r_ready !== 1'b1 || r_rdata !== 32'h3fc0_0093) begin
            fail_cnt++;
            $display("FAIL rst_preserve0: got ready=%b rdata=%h, expected 1/3fc00093", r_ready, r_rdata);
        end
        access(32'h0000_03FC, 32'h0, 4'b0000, 1'b0);
        asserts_cnt++;
        if (r_rdata !== 32'h12BB_56DD) begin
            fail_cnt++;
            $display("FAIL rst_preserve3fc: got %h, expected 12bb56dd", r_rdata);
        end
    endtask

    initial begin
        asserts_cnt = 0;
        fail_cnt    = 0;
        prog[0] = 32'h3fc0_0093;
        prog[1] = 32'h0000_a023;
        prog[2] = 32'h0000_a103;
        prog[3] = 32'h0011_0113;
        prog[4] = 32'h0020_a023;
        prog[5] = 32'hff5f_f06f;
        test_reset();
        test_read_program();
        test_byte_write();
        test_back_to_back();
        test_out_of_range();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts_cnt, fail_cnt);
        $finish;
    end

endmodule
